// File: rtl/inst_fetch_ctrl_pkg.sv
// ============================================================================
// Package  : inst_fetch_ctrl_pkg
// Brief    : Shared widths, enable levels and fetch state encoding for fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fetch_ctrl_pkg;

  localparam int c_addr_w = 32;
  localparam int c_inst_w = 32;

  localparam logic c_enable  = 1'b1;
  localparam logic c_disable = 1'b0;

  localparam logic [c_inst_w-1:0] c_zero_word = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_ctrl_fetch_queue.sv
// ============================================================================
// Module   : inst_fetch_ctrl_fetch_queue
// Brief    : Circular FIFO of {pc, inst} with push/pop/flush and entry count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_ctrl_fetch_queue
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int INST_W = c_inst_w,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [INST_W-1:0]            i_push_inst,
  input  logic [ADDR_W-1:0]            i_push_pc,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic                         o_valid,
  output logic [INST_W-1:0]            o_head_inst,
  output logic [ADDR_W-1:0]            o_head_pc,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; the count alone qualifies it.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_inst_mem[r_wr_ptr] <= i_push_inst;
      r_pc_mem[r_wr_ptr]   <= i_push_pc;
    end
  end

  assign o_valid     = ~w_empty;
  assign o_head_inst = w_empty ? INST_W'(c_zero_word) : r_inst_mem[r_rd_ptr];
  assign o_head_pc   = w_empty ? '0 : r_pc_mem[r_rd_ptr];
  assign o_count     = r_count;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
// ============================================================================
// Module   : inst_fetch_ctrl
// Brief    : PC owner and ROM fetch sequencer feeding decode through a queue.
//            Optional bounds check enabled by macro FETCH_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int                 ADDR_W    = c_addr_w,
  parameter int                 INST_W    = c_inst_w,
  parameter int                 Q_DEPTH   = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int                 ROM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_romEnable,
  output logic [ADDR_W-1:0] o_romAddr,
  input  logic [INST_W-1:0] i_romInst,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirectPc,
  output logic              o_instValid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_instPc,
  input  logic              i_instReady,
  output logic              o_fetchFault
);

  localparam int              CNT_W       = $clog2(Q_DEPTH) + 1;
  localparam logic [ADDR_W:0] c_rom_limit = (ADDR_W+1)'(ROM_WORDS * 4);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic c_bounds_en = c_enable;
`else
  localparam logic c_bounds_en = c_disable;
`endif

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic [CNT_W-1:0]  w_count;
  logic              w_q_valid;
  logic              w_pop;
  logic              w_fetch;
  logic              w_out_of_range;
  logic              w_bounds_stop;

  assign w_redirect_pc  = i_redirectPc & ~ADDR_W'(3);
  assign w_out_of_range = ({1'b0, r_pc} >= c_rom_limit);
  assign w_bounds_stop  = c_bounds_en & w_out_of_range;
  // A redirect flushes the queue, so a same-cycle handshake is not a pop.
  assign w_pop          = w_q_valid & i_instReady & ~i_redirect;

  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = c_disable;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (!i_redirect) begin
          if (w_bounds_stop)
            w_state_nxt = ST_FAULT;
          else if (w_count < CNT_W'(Q_DEPTH) || w_pop)
            w_fetch = c_enable;
        end
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      ST_FAULT: begin
        if (i_redirect) w_state_nxt = ST_RUN;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_redirect)
      w_pc_nxt = w_redirect_pc;
    else if (w_fetch)
      w_pc_nxt = r_pc + ADDR_W'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  inst_fetch_ctrl_fetch_queue #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (Q_DEPTH)
  ) u_fetch_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_fetch),
    .i_push_inst (i_romInst),
    .i_push_pc   (r_pc),
    .i_pop       (w_pop),
    .i_flush     (i_redirect),
    .o_valid     (w_q_valid),
    .o_head_inst (o_inst),
    .o_head_pc   (o_instPc),
    .o_count     (w_count)
  );

  assign o_romEnable = w_fetch;
  assign o_romAddr   = r_pc;
  assign o_instValid = w_q_valid;

`ifdef FETCH_BOUNDS_CHECK_EN
  assign o_fetchFault = (r_state == ST_FAULT);
`else
  assign o_fetchFault = c_disable;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
// ============================================================================
// Module   : tb_inst_fetch_ctrl
// Brief    : Scoreboard bench for inst_fetch_ctrl; follows FETCH_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_ctrl;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              o_romEnable;
  logic [ADDR_W-1:0] o_romAddr;
  logic [INST_W-1:0] i_romInst;
  logic              i_redirect;
  logic [ADDR_W-1:0] i_redirectPc;
  logic              o_instValid;
  logic [INST_W-1:0] o_inst;
  logic [ADDR_W-1:0] o_instPc;
  logic              i_instReady;
  logic              o_fetchFault;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } exp_t;

  exp_t sb[$];
  int   tests     = 0;
  int   failed    = 0;
  int   pops_seen = 0;

  always #5 clk = ~clk;

  // ROM model: word i holds value i.
  assign i_romInst = INST_W'(o_romAddr >> 2);

  inst_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .o_romEnable  (o_romEnable),
    .o_romAddr    (o_romAddr),
    .i_romInst    (i_romInst),
    .i_redirect   (i_redirect),
    .i_redirectPc (i_redirectPc),
    .o_instValid  (o_instValid),
    .o_inst       (o_inst),
    .o_instPc     (o_instPc),
    .i_instReady  (i_instReady),
    .o_fetchFault (o_fetchFault)
  );

  task automatic expect_from(input logic [ADDR_W-1:0] start, input int n);
    exp_t e;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      e.pc   = start + ADDR_W'(4 * i);
      e.inst = INST_W'(e.pc >> 2);
      sb.push_back(e);
    end
  endtask

  // Each cycle: pop the scoreboard on a handshake at the negedge, end at posedge+1.
  task automatic cycle(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!rst) begin
        if (o_instValid && i_instReady && !i_redirect) begin
          tests++;
          if (sb.size() == 0) begin
            failed++;
            $display("FAIL sb_pop: got head pc=%h, required no output", o_instPc);
          end else begin
            e = sb.pop_front();
            pops_seen++;
            if (o_instPc !== e.pc || o_inst !== e.inst) begin
              failed++;
              $display("FAIL sb_head: got pc=%h inst=%h, required pc=%h inst=%h",
                       o_instPc, o_inst, e.pc, e.inst);
            end
          end
        end else if (!o_instValid) begin
          tests++;
          if (o_inst !== '0 || o_instPc !== '0) begin
            failed++;
            $display("FAIL idle_zero: got inst=%h pc=%h, required 0/0", o_inst, o_instPc);
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    tests++; if (o_romEnable !== 1'b0) begin failed++; $display("FAIL rst_romEnable: got %b, required 0", o_romEnable); end
    tests++; if (o_romAddr !== '0) begin failed++; $display("FAIL rst_romAddr: got %h, required 0", o_romAddr); end
    tests++; if (o_instValid !== 1'b0) begin failed++; $display("FAIL rst_instValid: got %b, required 0", o_instValid); end
    tests++; if (o_inst !== '0 || o_instPc !== '0) begin failed++; $display("FAIL rst_head: got %h/%h, required 0/0", o_inst, o_instPc); end
    tests++; if (o_fetchFault !== 1'b0) begin failed++; $display("FAIL rst_fault: got %b, required 0", o_fetchFault); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int base;
    i_instReady = 1'b1;
    cycle(1);
    expect_from('0, 64);
    rst = 1'b0;
    #1;
    tests++; if (o_romEnable !== 1'b0) begin failed++; $display("FAIL idle_nofetch: got %b, required 0", o_romEnable); end
    cycle(1);
    tests++; if (o_romEnable !== 1'b1 || o_instValid !== 1'b0) begin failed++; $display("FAIL run_first: got en=%b valid=%b, required 1/0", o_romEnable, o_instValid); end
    cycle(1);
    tests++; if (o_instValid !== 1'b1 || o_instPc !== '0) begin failed++; $display("FAIL first_valid: got valid=%b pc=%h, required 1/0", o_instValid, o_instPc); end
    base = pops_seen;
    cycle(10);
    tests++; if (pops_seen - base != 10) begin failed++; $display("FAIL throughput: got %0d pops, required 10", pops_seen - base); end
    tests++; if (o_romAddr !== 32'h2C) begin failed++; $display("FAIL stream_pc: got %h, required 2c", o_romAddr); end
  endtask

  task automatic test_stall();
    rst = 1'b1;
    i_instReady = 1'b0;
    #1;
    cycle(1);
    expect_from('0, 64);
    rst = 1'b0;
    cycle(7);
    tests++; if (o_instValid !== 1'b1 || o_instPc !== '0 || o_inst !== '0) begin failed++; $display("FAIL stall_head: got valid=%b pc=%h, required 1/0", o_instValid, o_instPc); end
    tests++; if (o_romEnable !== 1'b0) begin failed++; $display("FAIL stall_enable: got %b, required 0", o_romEnable); end
    tests++; if (o_romAddr !== 32'h8) begin failed++; $display("FAIL stall_pc: got %h, required 8", o_romAddr); end
  endtask

  task automatic test_back_to_back();
    int base;
    i_instReady = 1'b1;
    #1;
    tests++; if (o_romEnable !== 1'b1) begin failed++; $display("FAIL full_pop_fetch: got %b, required 1", o_romEnable); end
    cycle(1);
    tests++; if (o_instPc !== 32'h4 || o_romAddr !== 32'hC) begin failed++; $display("FAIL b2b_order: got head=%h pc=%h, required 4/c", o_instPc, o_romAddr); end
    cycle(5);
    i_instReady = 1'b0;
    #1;
    tests++; if (o_romEnable !== 1'b0) begin failed++; $display("FAIL b2b_count: got en=%b, required 0 (queue stays full)", o_romEnable); end
    i_instReady = 1'b1;
    base = pops_seen;
    cycle(4);
    tests++; if (pops_seen - base != 4) begin failed++; $display("FAIL b2b_rate: got %0d pops, required 4", pops_seen - base); end
  endtask

  task automatic test_redirect();
    i_redirect   = 1'b1;
    i_redirectPc = 32'h23;
    expect_from(32'h20, 64);
    #1;
    tests++; if (o_romEnable !== 1'b0 || o_instValid !== 1'b1) begin failed++; $display("FAIL redir_cycle: got en=%b valid=%b, required 0/1", o_romEnable, o_instValid); end
    cycle(1);
    i_redirect = 1'b0;
    #1;
    tests++; if (o_instValid !== 1'b0 || o_romAddr !== 32'h20 || o_romEnable !== 1'b1) begin failed++; $display("FAIL redir_flush: got valid=%b pc=%h en=%b, required 0/20/1", o_instValid, o_romAddr, o_romEnable); end
    cycle(1);
    tests++; if (o_instValid !== 1'b1 || o_instPc !== 32'h20 || o_inst !== 32'h8) begin failed++; $display("FAIL redir_target: got valid=%b pc=%h inst=%h, required 1/20/8", o_instValid, o_instPc, o_inst); end
  endtask

  task automatic test_bounds();
    int base;
    i_redirect   = 1'b1;
    i_redirectPc = 32'h30;
`ifdef FETCH_BOUNDS_CHECK_EN
    expect_from(32'h30, 4);
`else
    expect_from(32'h30, 64);
`endif
    cycle(1);
    i_redirect = 1'b0;
    base = pops_seen;
    cycle(8);
`ifdef FETCH_BOUNDS_CHECK_EN
    tests++; if (o_fetchFault !== 1'b1 || o_romEnable !== 1'b0) begin failed++; $display("FAIL fault_set: got fault=%b en=%b, required 1/0", o_fetchFault, o_romEnable); end
    tests++; if (pops_seen - base != 4 || o_instValid !== 1'b0) begin failed++; $display("FAIL fault_drain: got %0d pops valid=%b, required 4/0", pops_seen - base, o_instValid); end
    tests++; if (o_romAddr !== 32'h40) begin failed++; $display("FAIL fault_pc: got %h, required 40", o_romAddr); end
    i_redirect   = 1'b1;
    i_redirectPc = '0;
    expect_from('0, 64);
    cycle(1);
    i_redirect = 1'b0;
    #1;
    tests++; if (o_fetchFault !== 1'b0 || o_romEnable !== 1'b1) begin failed++; $display("FAIL fault_clear: got fault=%b en=%b, required 0/1", o_fetchFault, o_romEnable); end
    cycle(1);
    tests++; if (o_instValid !== 1'b1 || o_instPc !== '0) begin failed++; $display("FAIL fault_resume: got valid=%b pc=%h, required 1/0", o_instValid, o_instPc); end
`else
    tests++; if (o_fetchFault !== 1'b0 || o_romEnable !== 1'b1) begin failed++; $display("FAIL alias_nofault: got fault=%b en=%b, required 0/1", o_fetchFault, o_romEnable); end
    tests++; if (pops_seen - base != 7) begin failed++; $display("FAIL alias_pops: got %0d, required 7", pops_seen - base); end
    tests++; if (o_romAddr !== 32'h50) begin failed++; $display("FAIL alias_pc: got %h, required 50", o_romAddr); end
`endif
  endtask

  task automatic test_async_reset();
    cycle(2);
    #2;
    rst = 1'b1;
    #1;
    tests++; if (o_instValid !== 1'b0 || o_inst !== '0 || o_instPc !== '0) begin failed++; $display("FAIL arst_head: got valid=%b inst=%h pc=%h, required 0/0/0", o_instValid, o_inst, o_instPc); end
    tests++; if (o_romAddr !== '0 || o_romEnable !== 1'b0 || o_fetchFault !== 1'b0) begin failed++; $display("FAIL arst_fetch: got pc=%h en=%b fault=%b, required 0/0/0", o_romAddr, o_romEnable, o_fetchFault); end
    expect_from('0, 64);
    cycle(1);
    rst = 1'b0;
    cycle(2);
    tests++; if (o_instValid !== 1'b1 || o_instPc !== '0) begin failed++; $display("FAIL arst_restart: got valid=%b pc=%h, required 1/0", o_instValid, o_instPc); end
    cycle(3);
  endtask

  initial begin
    rst          = 1'b0;
    i_redirect   = 1'b0;
    i_redirectPc = '0;
    i_instReady  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_redirect();
    test_bounds();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
